ra_stack_spec: RTL and testbench

//  Return-address stack with split speculative/committed state. Fetch pushes
//  (call) and pops (return) speculatively; commit stage maintains an

---
 rtl/ra_stack_spec.sv | 116 +++++++++++
 tb/tb_ra_stack_spec.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ra_stack_spec.sv
// ============================================================================
//  Module   : ra_stack_spec
//  Brief    : Return-address stack, speculative copy restored from committed.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ra_stack_spec #(
    parameter int ADDR     = 32,
    parameter int RA_DEPTH = 8,
    parameter int INCR     = 4
) (
    input  logic                          clk,
    input  logic                          reset_,
    input  logic                          spec_call_,
    input  logic [ADDR-1:0]               spec_call_pc,
    input  logic                          spec_ret_,
    output logic                          ret_v,
    output logic [ADDR-1:0]               ret_addr,
    input  logic                          cmt_call_,
    input  logic [ADDR-1:0]               cmt_call_pc,
    input  logic                          cmt_ret_,
    input  logic                          flush_,
    output logic [$clog2(RA_DEPTH+1)-1:0] spec_cnt,
    output logic [$clog2(RA_DEPTH+1)-1:0] cmt_cnt
);

    localparam int PW = $clog2(RA_DEPTH);
    localparam int CW = $clog2(RA_DEPTH+1);
    localparam logic [CW-1:0]   C_FULL = CW'(RA_DEPTH);
    localparam logic [ADDR-1:0] C_INCR = ADDR'(INCR);

    logic [ADDR-1:0] spec_arr_q [RA_DEPTH];
    logic [ADDR-1:0] spec_arr_d [RA_DEPTH];
    logic [PW-1:0]   spec_ptr_q, spec_ptr_d;
    logic [CW-1:0]   spec_cnt_q, spec_cnt_d;

    logic [ADDR-1:0] cmt_arr_q [RA_DEPTH];
    logic [ADDR-1:0] cmt_arr_d [RA_DEPTH];
    logic [PW-1:0]   cmt_ptr_q, cmt_ptr_d;
    logic [CW-1:0]   cmt_cnt_q, cmt_cnt_d;

    logic w_spec_call, w_spec_ret, w_cmt_call, w_cmt_ret, w_flush;

    assign w_spec_call = ~spec_call_;
    assign w_spec_ret  = ~spec_ret_;
    assign w_cmt_call  = ~cmt_call_;
    assign w_cmt_ret   = ~cmt_ret_;
    assign w_flush     = ~flush_;

    // Committed next state; the speculative side may copy it on flush.
    always_comb begin
        cmt_arr_d = cmt_arr_q;
        cmt_ptr_d = cmt_ptr_q;
        cmt_cnt_d = cmt_cnt_q;
        if (w_cmt_call && w_cmt_ret && (cmt_cnt_q != '0)) begin
            cmt_arr_d[cmt_ptr_q - PW'(1)] = cmt_call_pc + C_INCR;
        end else if (w_cmt_call) begin
            cmt_arr_d[cmt_ptr_q] = cmt_call_pc + C_INCR;
            cmt_ptr_d = cmt_ptr_q + PW'(1);
            if (cmt_cnt_q != C_FULL)
                cmt_cnt_d = cmt_cnt_q + CW'(1);
        end else if (w_cmt_ret && (cmt_cnt_q != '0)) begin
            cmt_ptr_d = cmt_ptr_q - PW'(1);
            cmt_cnt_d = cmt_cnt_q - CW'(1);
        end
    end

    always_comb begin
        spec_arr_d = spec_arr_q;
        spec_ptr_d = spec_ptr_q;
        spec_cnt_d = spec_cnt_q;
        if (w_flush) begin
            spec_arr_d = cmt_arr_d;
            spec_ptr_d = cmt_ptr_d;
            spec_cnt_d = cmt_cnt_d;
        end else if (w_spec_call && w_spec_ret && (spec_cnt_q != '0)) begin
            spec_arr_d[spec_ptr_q - PW'(1)] = spec_call_pc + C_INCR;
        end else if (w_spec_call) begin
            spec_arr_d[spec_ptr_q] = spec_call_pc + C_INCR;
            spec_ptr_d = spec_ptr_q + PW'(1);
            if (spec_cnt_q != C_FULL)
                spec_cnt_d = spec_cnt_q + CW'(1);
        end else if (w_spec_ret && (spec_cnt_q != '0)) begin
            spec_ptr_d = spec_ptr_q - PW'(1);
            spec_cnt_d = spec_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            spec_arr_q <= '{default: '0};
            spec_ptr_q <= '0;
            spec_cnt_q <= '0;
            cmt_arr_q  <= '{default: '0};
            cmt_ptr_q  <= '0;
            cmt_cnt_q  <= '0;
        end else begin
            spec_arr_q <= spec_arr_d;
            spec_ptr_q <= spec_ptr_d;
            spec_cnt_q <= spec_cnt_d;
            cmt_arr_q  <= cmt_arr_d;
            cmt_ptr_q  <= cmt_ptr_d;
            cmt_cnt_q  <= cmt_cnt_d;
        end
    end

    // Top is visible from state alone, so a popping cycle still shows the popped value.
    assign ret_v    = (spec_cnt_q != '0);
    assign ret_addr = ret_v ? spec_arr_q[spec_ptr_q - PW'(1)] : '0;
    assign spec_cnt = spec_cnt_q;
    assign cmt_cnt  = cmt_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ra_stack_spec.sv
// ============================================================================
//  Module   : tb_ra_stack_spec
//  Brief    : Directed bench for ra_stack_spec against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ra_stack_spec;

    localparam int ADDR  = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH+1);

    typedef logic [ADDR-1:0] q_t [$];

    logic            clk = 1'b0;
    logic            reset_;
    logic            spec_call_, spec_ret_, cmt_call_, cmt_ret_, flush_;
    logic [ADDR-1:0] spec_call_pc, cmt_call_pc;
    logic            ret_v;
    logic [ADDR-1:0] ret_addr;
    logic [CW-1:0]   spec_cnt, cmt_cnt;

    int checks = 0;
    int errors = 0;

    q_t sq;
    q_t cq;

    ra_stack_spec #(.ADDR(ADDR), .RA_DEPTH(DEPTH), .INCR(4)) dut (
        .clk          (clk),
        .reset_       (reset_),
        .spec_call_   (spec_call_),
        .spec_call_pc (spec_call_pc),
        .spec_ret_    (spec_ret_),
        .ret_v        (ret_v),
        .ret_addr     (ret_addr),
        .cmt_call_    (cmt_call_),
        .cmt_call_pc  (cmt_call_pc),
        .cmt_ret_     (cmt_ret_),
        .flush_       (flush_),
        .spec_cnt     (spec_cnt),
        .cmt_cnt      (cmt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [ADDR-1:0] act, input logic [ADDR-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic q_t apply(input q_t q, input bit call, input logic [ADDR-1:0] pc, input bit ret);
        q_t r = q;
        if (call && ret && r.size() > 0) begin
            r[r.size()-1] = pc + 4;
        end else if (call) begin
            if (r.size() == DEPTH) void'(r.pop_front());
            r.push_back(pc + 4);
        end else if (ret && r.size() > 0) begin
            void'(r.pop_back());
        end
        return r;
    endfunction

    // Model: commit stack evolves on its own; speculative copies it on flush.
    initial begin
        forever begin
            @(posedge clk or negedge reset_);
            if (!reset_) begin
                sq.delete();
                cq.delete();
            end else begin
                cq = apply(cq, !cmt_call_, cmt_call_pc, !cmt_ret_);
                if (!flush_) sq = cq;
                else         sq = apply(sq, !spec_call_, spec_call_pc, !spec_ret_);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset_ === 1'b1) begin
                check("m_ret_v",    ADDR'(ret_v),    ADDR'(sq.size() != 0));
                check("m_ret_addr", ret_addr,        (sq.size() != 0) ? sq[sq.size()-1] : '0);
                check("m_spec_cnt", ADDR'(spec_cnt), ADDR'(sq.size()));
                check("m_cmt_cnt",  ADDR'(cmt_cnt),  ADDR'(cq.size()));
            end
        end
    end

    task automatic idle();
        spec_call_ = 1'b1; spec_ret_ = 1'b1; cmt_call_ = 1'b1; cmt_ret_ = 1'b1; flush_ = 1'b1;
        spec_call_pc = '0; cmt_call_pc = '0;
    endtask

    task automatic cyc(input bit sc, input logic [ADDR-1:0] spc, input bit sr,
                       input bit cc, input logic [ADDR-1:0] cpc, input bit cr, input bit fl);
        spec_call_ = !sc; spec_call_pc = spc; spec_ret_ = !sr;
        cmt_call_  = !cc; cmt_call_pc  = cpc; cmt_ret_  = !cr;
        flush_     = !fl;
        @(negedge clk);
        idle();
    endtask

    initial begin
        reset_ = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        check("rst_ret_v",    ADDR'(ret_v),    '0);
        check("rst_ret_addr", ret_addr,        '0);
        check("rst_spec_cnt", ADDR'(spec_cnt), '0);
        check("rst_cmt_cnt",  ADDR'(cmt_cnt),  '0);
        reset_ = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of traffic
        cyc(1, 32'h700, 0, 1, 32'h800, 0, 0);
        cyc(1, 32'h710, 0, 0, 0, 0, 0);
        check("pre_rst_spec_cnt", ADDR'(spec_cnt), 32'd2);
        spec_call_ = 1'b0; spec_call_pc = 32'h720;
        #3 reset_ = 1'b0;
        #1;
        check("arst_ret_v",    ADDR'(ret_v),    '0);
        check("arst_ret_addr", ret_addr,        '0);
        check("arst_spec_cnt", ADDR'(spec_cnt), '0);
        check("arst_cmt_cnt",  ADDR'(cmt_cnt),  '0);
        @(negedge clk);
        idle();
        reset_ = 1'b1;
        @(negedge clk);

        // Basic push / pop / underflow
        cyc(1, 32'h100, 0, 0, 0, 0, 0);
        cyc(1, 32'h200, 0, 0, 0, 0, 0);
        check("t2_addr", ret_addr,        32'h204);
        check("t2_cnt",  ADDR'(spec_cnt), 32'd2);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("t2_pop1", ret_addr, 32'h104);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("t2_empty_v", ADDR'(ret_v), '0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("t2_under_cnt",  ADDR'(spec_cnt), '0);
        check("t2_under_addr", ret_addr,        '0);

        // Overflow evicts the oldest entry
        for (int k = 1; k <= 9; k++) cyc(1, 32'h10 * k, 0, 0, 0, 0, 0);
        check("t3_cnt", ADDR'(spec_cnt), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("t3_pop_addr", ret_addr, 32'h94 - 32'h10 * i);
            cyc(0, 0, 1, 0, 0, 0, 0);
        end
        check("t3_empty_v", ADDR'(ret_v), '0);

        // Flush restores from committed copy
        cyc(0, 0, 0, 1, 32'h1000, 0, 0);
        cyc(1, 32'h1000, 0, 0, 0, 0, 0);
        cyc(1, 32'h2000, 0, 0, 0, 0, 0);
        cyc(1, 32'h3000, 0, 0, 0, 0, 0);
        check("t4_pre_addr", ret_addr, 32'h3004);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("t4_addr",     ret_addr,        32'h1004);
        check("t4_spec_cnt", ADDR'(spec_cnt), 32'd1);
        check("t4_cmt_cnt",  ADDR'(cmt_cnt),  32'd1);

        // Call + return in the same cycle replaces top
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(1, 32'h100, 0, 0, 0, 0, 0);
        spec_call_ = 1'b0; spec_call_pc = 32'h400; spec_ret_ = 1'b0;
        #1;
        check("t5_same_cycle", ret_addr, 32'h104);
        @(negedge clk);
        idle();
        check("t5_addr", ret_addr,        32'h404);
        check("t5_cnt",  ADDR'(spec_cnt), 32'd1);

        // Flush with a same-cycle commit call; speculative call ignored
        cyc(1, 32'h6000, 0, 1, 32'h5000, 0, 1);
        check("t6_addr",     ret_addr,        32'h5004);
        check("t6_spec_cnt", ADDR'(spec_cnt), 32'd2);
        check("t6_cmt_cnt",  ADDR'(cmt_cnt),  32'd2);

        // Commit-side call+ret replace, then pop, spec untouched
        cyc(0, 0, 0, 1, 32'h7000, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("cmt_cnt_after", ADDR'(cmt_cnt), 32'd1);
        check("spec_untouched", ret_addr, 32'h5004);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("flush_after_cmt", ret_addr, 32'h1004);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
